fetch_redirect: RTL and testbench

FETCH_REDIRECT -- requirements
Module: fetch_redirect

---
 rtl/fetch_redirect.sv | 193 +++++++++++++++++++
 tb/tb_fetch_redirect.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect.sv
// fetch_redirect: in-order instruction fetch front end with branch redirect.
//
// Issues one 32-bit fetch per cycle while the in-flight plus buffered
// instruction total is below DEPTH. Returned words are paired with the PC of
// the request that produced them and queued for decode. A taken branch
// flushes everything buffered. Responses still owed by memory for the old
// path are dropped as they arrive.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   DEPTH     response FIFO size and in-flight limit (power of two, >= 2)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   branch_taken, branch_target   redirect pulse and new PC
//   imem_addr, imem_rmask         fetch request (rmask 4'hF when issuing)
//   imem_resp, imem_rdata         in-order response pulse and data
//   dq_valid, dq_ready            decode handshake
//   dq_pc, dq_inst                head instruction PC and word
//   flush                         pipeline flush, same cycle as branch_taken
//
// Optional build macro FETCH_REDIRECT_STATS_EN adds the 32-bit wrapping
// counters redirect_count (one per redirect) and dropped_count (one per
// discarded response).

module fetch_redirect #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  output logic        dq_valid,
  input  logic        dq_ready,
  output logic [31:0] dq_pc,
  output logic [31:0] dq_inst,
  output logic        flush
`ifdef FETCH_REDIRECT_STATS_EN
  ,
  output logic [31:0] redirect_count,
  output logic [31:0] dropped_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;     // requests sent, response not yet seen
  logic [CW-1:0] fcnt_q, fcnt_d;   // response FIFO occupancy
  logic [CW-1:0] drop_q, drop_d;   // old-path responses still to discard
  logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [PW-1:0] f_wr_q, f_wr_d, f_rd_q, f_rd_d;

  logic [31:0]   tag_mem  [DEPTH];
  entry_t        fifo_mem [DEPTH];
  entry_t        head;

  logic req, resp_v, keep, drop, pop, redir;

  // A response coincident with a redirect belongs to the old path, so it is
  // never kept; in DRAIN every response is an old-path one.
  assign resp_v = imem_resp && !rst;
  assign redir  = branch_taken && !rst;
  assign req    = !rst && !branch_taken &&
                  (({1'b0, out_q} + {1'b0, fcnt_q}) < DEPTH_W);
  assign keep   = resp_v && !branch_taken && (state_q == RUN);
  assign drop   = resp_v && !keep;
  assign pop    = dq_valid && dq_ready;

  assign head       = fifo_mem[f_rd_q];
  assign dq_valid   = !rst && !branch_taken && (fcnt_q != '0);
  assign dq_pc      = dq_valid ? head.pc   : 32'h0;
  assign dq_inst    = dq_valid ? head.inst : 32'h0;
  assign imem_addr  = pc_q;
  assign imem_rmask = req ? 4'hF : 4'h0;
  assign flush      = redir;

  always_comb begin
    pc_d     = pc_q;
    out_d    = out_q;
    fcnt_d   = fcnt_q;
    drop_d   = drop_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    f_wr_d   = f_wr_q;
    f_rd_d   = f_rd_q;

    case ({req, resp_v})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: ;
    endcase

    if (req) begin
      pc_d     = pc_q + 32'd4;
      tag_wr_d = tag_wr_q + PW'(1);
    end
    if (keep) begin
      tag_rd_d = tag_rd_q + PW'(1);
      f_wr_d   = f_wr_q + PW'(1);
    end
    if (pop)
      f_rd_d = f_rd_q + PW'(1);

    case ({keep, pop})
      2'b10:   fcnt_d = fcnt_q + CW'(1);
      2'b01:   fcnt_d = fcnt_q - CW'(1);
      default: ;
    endcase

    if (drop && drop_q != '0)
      drop_d = drop_q - CW'(1);

    // Everything still owed by memory is old-path after a redirect, except
    // the response arriving this very cycle, which is discarded here.
    if (redir) begin
      pc_d     = branch_target;
      fcnt_d   = '0;
      f_wr_d   = '0;
      f_rd_d   = '0;
      tag_wr_d = '0;
      tag_rd_d = '0;
      drop_d   = out_q - CW'(resp_v);
    end

    state_d = (drop_d != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      out_q    <= '0;
      fcnt_q   <= '0;
      drop_q   <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      f_wr_q   <= '0;
      f_rd_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_q    <= out_d;
      fcnt_q   <= fcnt_d;
      drop_q   <= drop_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      f_wr_q   <= f_wr_d;
      f_rd_q   <= f_rd_d;
    end
  end

  // Storage needs no reset: pointers and counts define what is live.
  always_ff @(posedge clk) begin
    if (req)
      tag_mem[tag_wr_q] <= pc_q;
    if (keep)
      fifo_mem[f_wr_q] <= '{pc: tag_mem[tag_rd_q], inst: imem_rdata};
  end

`ifdef FETCH_REDIRECT_STATS_EN
  logic [31:0] redir_cnt_q, drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      redir_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (redir) redir_cnt_q <= redir_cnt_q + 32'd1;
      if (drop)  drop_cnt_q  <= drop_cnt_q + 32'd1;
    end
  end

  assign redirect_count = redir_cnt_q;
  assign dropped_count  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// Testbench for fetch_redirect. It uses an in-order memory with a random
// 1..3 cycle latency. A reference model tracks in-flight requests as a queue
// of {pc, stale} records and tracks the decode queue as a queue of
// {pc, inst}. Each cycle the DUT outputs are compared against that model.

module tb_fetch_redirect;
  localparam logic [31:0] RPC   = 32'h1eceb000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, branch_taken, imem_resp, dq_ready;
  logic [31:0] branch_target, imem_rdata;
  logic [31:0] imem_addr, dq_pc, dq_inst;
  logic [3:0]  imem_rmask;
  logic        dq_valid, flush;
`ifdef FETCH_REDIRECT_STATS_EN
  logic [31:0] redirect_count, dropped_count;
`endif

  fetch_redirect #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .dq_valid(dq_valid), .dq_ready(dq_ready),
    .dq_pc(dq_pc), .dq_inst(dq_inst), .flush(flush)
`ifdef FETCH_REDIRECT_STATS_EN
    , .redirect_count(redirect_count), .dropped_count(dropped_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mr_t;

  int errors = 0, checks = 0;
  fl_t infl[$];
  ent_t fq[$];
  mr_t memq[$];
  logic [31:0] pc_m;
  int cyc = 0, lat_lo = 1, lat_hi = 1;
  int unsigned m_redirects = 0, m_drops = 0;
  bit o_req, o_valid;
  logic [31:0] o_addr, o_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h5a5a0f0f;
  endfunction

  // One non-reset cycle: drive inputs, compare against the model, advance it.
  task automatic cycle(input bit br, input logic [31:0] tgt, input bit rdy);
    bit rsp, ereq, evld;
    logic [31:0] rd;
    fl_t h;
    @(negedge clk);
    rsp = (memq.size() != 0) && (memq[0].due <= cyc);
    rd  = rsp ? mem_word(memq[0].addr) : $urandom;
    if (rsp) void'(memq.pop_front());
    rst = 1'b0; branch_taken = br; branch_target = tgt; dq_ready = rdy;
    imem_resp = rsp; imem_rdata = rd;
    ereq = !br && (infl.size() + fq.size() < DEPTH);
    evld = (fq.size() != 0) && !br;
    #1;
    checks++;
    if (imem_rmask !== (ereq ? 4'hF : 4'h0)) begin
      errors++; $display("FAIL rmask cyc=%0d got=%h exp=%h", cyc, imem_rmask, ereq ? 4'hF : 4'h0);
    end
    if (ereq) begin
      checks++;
      if (imem_addr !== pc_m) begin
        errors++; $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, pc_m);
      end
    end
    checks++;
    if (dq_valid !== evld) begin
      errors++; $display("FAIL dq_valid cyc=%0d got=%b exp=%b", cyc, dq_valid, evld);
    end
    if (evld) begin
      checks++;
      if (dq_pc !== fq[0].pc || dq_inst !== fq[0].inst) begin
        errors++; $display("FAIL dq_head cyc=%0d got=%h/%h exp=%h/%h", cyc, dq_pc, dq_inst, fq[0].pc, fq[0].inst);
      end
    end
    checks++;
    if (flush !== br) begin
      errors++; $display("FAIL flush cyc=%0d got=%b exp=%b", cyc, flush, br);
    end
`ifdef FETCH_REDIRECT_STATS_EN
    checks++;
    if (redirect_count !== m_redirects || dropped_count !== m_drops) begin
      errors++; $display("FAIL stats cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, redirect_count, dropped_count, m_redirects, m_drops);
    end
`endif
    o_req = (imem_rmask === 4'hF); o_addr = imem_addr;
    o_valid = (dq_valid === 1'b1); o_pc = dq_pc;
    if (rsp) begin
      h = infl.pop_front();
      if (br || h.stale) m_drops++;
      else fq.push_back('{h.pc, rd});
    end
    if (br) begin
      foreach (infl[i]) infl[i].stale = 1'b1;
      fq.delete();
      pc_m = tgt;
      m_redirects++;
    end else begin
      if (evld && rdy) void'(fq.pop_front());
      if (ereq) begin
        infl.push_back('{pc_m, 1'b0});
        memq.push_back('{pc_m, cyc + int'($urandom_range(lat_hi, lat_lo))});
        pc_m = pc_m + 32'd4;
      end
    end
    cyc++;
  endtask

  // Reset cycles: memory flushes whatever it still owes; outputs must stay quiet.
  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = 1'b1;
      branch_taken = 1'($urandom_range(1, 0));
      branch_target = $urandom;
      dq_ready = 1'b1;
      imem_resp = (memq.size() != 0) ? 1'b1 : 1'($urandom_range(1, 0));
      imem_rdata = $urandom;
      if (memq.size() != 0) void'(memq.pop_front());
      #1;
      checks++;
      if (imem_rmask !== 4'h0 || dq_valid !== 1'b0 || flush !== 1'b0 || dq_pc !== 32'h0 || dq_inst !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got rmask=%h vld=%b flush=%b pc=%h inst=%h exp all zero",
                 cyc, imem_rmask, dq_valid, flush, dq_pc, dq_inst);
      end
      cyc++;
    end
    infl.delete(); fq.delete(); memq.delete();
    pc_m = RPC; m_redirects = 0; m_drops = 0;
  endtask

  task automatic test_reset();
    do_reset(3);
    cycle(1'b0, 32'h0, 1'b0);
    checks++;
    if (!o_req || o_addr !== RPC) begin
      errors++; $display("FAIL first_fetch got req=%b addr=%h exp req=1 addr=%h", o_req, o_addr, RPC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    int n;
    do_reset(3);
    lat_lo = 1; lat_hi = 1;
    exp = RPC; n = 0;
    for (int k = 0; k < 24; k++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (o_valid) begin
        checks++;
        if (o_pc !== exp) begin
          errors++; $display("FAIL stream_pc got=%h exp=%h", o_pc, exp);
        end
        exp = exp + 32'd4; n++;
      end
    end
    checks++;
    if (n < 12) begin
      errors++; $display("FAIL stream_count got=%0d exp>=12", n);
    end
  endtask

  task automatic test_stall();
    int nreq;
    do_reset(3);
    lat_lo = 1; lat_hi = 1;
    nreq = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 32'h0, 1'b0);
      if (o_req) nreq++;
    end
    checks++;
    if (nreq != 2) begin
      errors++; $display("FAIL stall_reqs got=%0d exp=2", nreq);
    end
    checks++;
    if (!o_valid || o_pc !== RPC) begin
      errors++; $display("FAIL stall_head got vld=%b pc=%h exp vld=1 pc=%h", o_valid, o_pc, RPC);
    end
    for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_branch();
    bit found;
    logic [31:0] got;
    do_reset(3);
    lat_lo = 3; lat_hi = 3;
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h1eceb100, 1'b0);
    found = 0; got = '0;
    for (int k = 0; k < 30 && !found; k++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (o_valid) begin found = 1; got = o_pc; end
    end
    checks++;
    if (!found || got !== 32'h1eceb100) begin
      errors++; $display("FAIL branch_first_pc found=%0d got=%h exp=1eceb100", found, got);
    end
  endtask

  task automatic test_coincident();
    bit found;
    logic [31:0] got;
    do_reset(3);
    lat_lo = 1; lat_hi = 1;
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    // Head valid and the second response arriving right now.
    cycle(1'b1, 32'h1eceb300, 1'b1);
    checks++;
    if (o_valid) begin
      errors++; $display("FAIL coincident_valid got=1 exp=0");
    end
    cycle(1'b0, 32'h0, 1'b0);
    checks++;
    if (!o_req || o_addr !== 32'h1eceb300) begin
      errors++; $display("FAIL coincident_refetch got req=%b addr=%h exp req=1 addr=1eceb300", o_req, o_addr);
    end
    found = 0; got = '0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (o_valid) begin found = 1; got = o_pc; end
    end
    checks++;
    if (!found || got !== 32'h1eceb300) begin
      errors++; $display("FAIL coincident_first_pc found=%0d got=%h exp=1eceb300", found, got);
    end
  endtask

  task automatic test_double_branch();
    bit found;
    logic [31:0] got;
    do_reset(3);
    lat_lo = 3; lat_hi = 3;
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h1eceb100, 1'b0);
    cycle(1'b1, 32'h1eceb200, 1'b0);
    found = 0; got = '0;
    for (int k = 0; k < 30 && !found; k++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (o_valid) begin found = 1; got = o_pc; end
    end
    checks++;
    if (!found || got !== 32'h1eceb200) begin
      errors++; $display("FAIL double_branch_pc found=%0d got=%h exp=1eceb200", found, got);
    end
`ifdef FETCH_REDIRECT_STATS_EN
    checks++;
    if (redirect_count !== 32'd2 || dropped_count !== 32'd2) begin
      errors++; $display("FAIL double_branch_stats got=%0d/%0d exp=2/2", redirect_count, dropped_count);
    end
`endif
  endtask

  task automatic test_reset_midop();
    bit found;
    logic [31:0] got;
    do_reset(3);
    lat_lo = 3; lat_hi = 3;
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    do_reset(3);
    lat_lo = 1; lat_hi = 2;
    cycle(1'b0, 32'h0, 1'b1);
    checks++;
    if (!o_req || o_addr !== RPC) begin
      errors++; $display("FAIL midop_restart got req=%b addr=%h exp req=1 addr=%h", o_req, o_addr, RPC);
    end
    found = 0; got = '0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (o_valid) begin found = 1; got = o_pc; end
    end
    checks++;
    if (!found || got !== RPC) begin
      errors++; $display("FAIL midop_first_pc found=%0d got=%h exp=%h", found, got, RPC);
    end
  endtask

  task automatic test_random();
    do_reset(3);
    lat_lo = 1; lat_hi = 3;
    for (int k = 0; k < 500; k++)
      cycle($urandom_range(99, 0) < 6, $urandom & 32'hFFFF_FFFC, $urandom_range(9, 0) < 7);
  endtask

  initial begin
    rst = 1'b1; branch_taken = 1'b0; branch_target = '0;
    imem_resp = 1'b0; imem_rdata = '0; dq_ready = 1'b0;
    pc_m = RPC;
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_coincident();
    test_double_branch();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
